io_gate_ctrl: RTL
=================

Name: io_gate_ctrl

Overview:
- Bus-side enforcer for the per-ASID I/O permission bitmap.
- Sits between the CPU data-bus master and the I/O device bus.
- Every non-privileged access that decodes to the I/O region is first checked against the bitmap: one bit per 256-byte I/O page, word address {asid, adr[19:13]}, bit adr[12:8].
- On a permitted check the cycle is forwarded to the device bus; on a denied check or a timeout it is terminated with a bus error and a fault record is captured.

Parameters:
IO_BASE, 32'hFFD00000, I/O region base; a hit is (s_adr_i & IO_MASK) == IO_BASE.
IO_MASK, 32'hFFF00000, I/O region decode mask.
CHK_TIMEOUT, 15, max cycles in CHECK waiting for bm_gate_en_i.
DEV_TIMEOUT, 255, max cycles in FWD waiting for m_ack_i.

Ports:
rst_i  in  1  synchronous active-high reset
clk_i  in  1  single clock, all logic on rising edge
s_cyc_i/s_stb_i/s_we_i  in  1 each  upstream bus cycle, strobe, write
s_sel_i  in  4  byte selects
s_adr_i  in  32  byte address
s_dat_i  in  32  write data
s_asid_i  in  6  current address-space id
s_priv_i  in  1  privileged access; bypasses check
s_ack_o/s_err_o  out  1 each  upstream completion / bus error
s_dat_o  out  32  read data
bm_cyc_o/bm_stb_o/bm_iocs_o  out  1 each  bitmap query request
bm_asid_o  out  6  query ASID
bm_adr_o  out  20  query address = s_adr_i[19:0]
bm_gate_i  in  1  permission bit, valid while bm_gate_en_i=1
bm_gate_en_i  in  1  query response strobe
m_cyc_o/m_stb_o/m_we_o  out  1 each  device bus cycle
m_sel_o  out  4  byte selects; m_adr_o  out  32; m_dat_o  out  32
m_ack_i  in  1  device ack; m_dat_i  in  32  device read data
fault_o  out  1  one-cycle pulse on denial or timeout
fault_adr_o  out  32; fault_asid_o  out  6; fault_cause_o  out  2 (1 deny, 2 check timeout, 3 device timeout)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, fault registers 0. Reset mid-operation drops every strobe the following cycle with no ack or err.
- Request latch: in IDLE, a request (s_cyc_i & s_stb_i) latches adr/we/sel/dat/asid into registers. All downstream outputs come from these registers and stay stable until the response.
- Non-I/O addresses: acked with err in 1 cycle (block only receives I/O-decoded traffic; a misdecode is a fault, cause 1).
- IDLE -> FWD: if s_priv_i=1. Decision is 1 cycle; device strobes are asserted the next cycle.
- IDLE -> CHECK: otherwise.
- CHECK:
  - Drive bm_cyc_o=bm_stb_o=bm_iocs_o=1 with bm_asid_o/bm_adr_o held, until bm_gate_en_i=1.
  - bm_gate_en_i & bm_gate_i -> FWD; query strobes drop the same edge.
  - bm_gate_en_i & ~bm_gate_i -> ERR, cause 1.
  - Counter reaches CHK_TIMEOUT -> ERR, cause 2.
  - If bm_gate_en_i and timeout coincide, the gate response wins.
- FWD:
  - m_cyc_o=m_stb_o=1 until m_ack_i.
  - On m_ack_i: capture m_dat_i (reads only; writes return 0), drop device strobes, -> RESP.
  - Counter reaches DEV_TIMEOUT -> ERR, cause 3, strobes dropped. An ack on the same cycle as the timeout wins.
- RESP: s_ack_o=1 for exactly 1 cycle with s_dat_o valid -> REL.
- ERR:
  - s_err_o=1 for 1 cycle; s_dat_o=0.
  - fault_o=1 for the same cycle; fault_adr_o/fault_asid_o/fault_cause_o updated and held until the next fault.
  - -> REL.
- REL: wait for s_stb_i=0, then -> IDLE. This prevents a held strobe from re-triggering.
- Data hygiene: s_dat_o is 0 whenever s_ack_o=0.
- Exclusivity: s_ack_o and s_err_o are never high together. Bitmap query and device cycle are never active together.
- Upstream abandon: if s_cyc_i drops in CHECK or FWD, drop all strobes, go to IDLE, and return no response.
- Counters: 8-bit; reset on every state entry; saturate, never wrap.
- Best-case latency: unprivileged read with 2-cycle bitmap and 1-cycle device gives ack 6 cycles after the strobe. Privileged read gives ack 3 cycles after the strobe.

Test Plan:
- Reset then idle: all outputs 0 for 10 cycles; assert rst_i during FWD -> m_stb_o=0 next cycle, no s_ack_o.
- asid=5, adr=32'hFFD02300, bitmap returns gate=1 after 2 cycles, device acks with 32'hA5A5_0001 -> one-cycle s_ack_o, s_dat_o=32'hA5A5_0001; bm_adr_o=20'h02300, bm_asid_o=5 while querying.
- Same access with gate=0 -> s_err_o pulse, no m_stb_o ever, fault_o=1, fault_adr_o=32'hFFD02300, fault_asid_o=5, fault_cause_o=1.
- s_priv_i=1 write 32'h1234 -> bm_stb_o never asserted, m_we_o=1, m_dat_o=32'h1234, s_ack_o after device ack.
- bm_gate_en_i held 0 -> s_err_o exactly CHK_TIMEOUT+1 cycles after CHECK entry, cause 2; device never acks -> cause 3 after DEV_TIMEOUT.
- s_stb_i held high after s_ack_o -> no second transaction until s_stb_i low for one cycle; s_cyc_i dropped in CHECK -> no response, returns to IDLE.

Source files
------------

// File: rtl/io_gate_ctrl_if.sv
// Signal bundle for io_gate_ctrl: upstream CPU bus, bitmap query port, device bus, fault record.
// The slave modport is the gate's view; master is the surrounding system's view.
interface io_gate_ctrl_if;
  logic        s_cyc_i, s_stb_i, s_we_i;
  logic [3:0]  s_sel_i;
  logic [31:0] s_adr_i, s_dat_i;
  logic [5:0]  s_asid_i;
  logic        s_priv_i;
  logic        s_ack_o, s_err_o;
  logic [31:0] s_dat_o;

  logic        bm_cyc_o, bm_stb_o, bm_iocs_o;
  logic [5:0]  bm_asid_o;
  logic [19:0] bm_adr_o;
  logic        bm_gate_i, bm_gate_en_i;

  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic        m_ack_i;
  logic [31:0] m_dat_i;

  logic        fault_o;
  logic [31:0] fault_adr_o;
  logic [5:0]  fault_asid_o;
  logic [1:0]  fault_cause_o;

  modport slave (
    input  s_cyc_i, s_stb_i, s_we_i, s_sel_i, s_adr_i, s_dat_i, s_asid_i, s_priv_i,
    output s_ack_o, s_err_o, s_dat_o,
    output bm_cyc_o, bm_stb_o, bm_iocs_o, bm_asid_o, bm_adr_o,
    input  bm_gate_i, bm_gate_en_i,
    output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
    input  m_ack_i, m_dat_i,
    output fault_o, fault_adr_o, fault_asid_o, fault_cause_o
  );

  modport master (
    output s_cyc_i, s_stb_i, s_we_i, s_sel_i, s_adr_i, s_dat_i, s_asid_i, s_priv_i,
    input  s_ack_o, s_err_o, s_dat_o,
    input  bm_cyc_o, bm_stb_o, bm_iocs_o, bm_asid_o, bm_adr_o,
    output bm_gate_i, bm_gate_en_i,
    input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
    output m_ack_i, m_dat_i,
    input  fault_o, fault_adr_o, fault_asid_o, fault_cause_o
  );
endinterface

// File: rtl/io_gate_ctrl.sv
// Per-ASID I/O permission gate: checks the bitmap, then forwards to the device bus or faults.
// Latency: privileged ack 3 cycles after strobe, unprivileged 6 best case; upstream is held until ack/err.
module io_gate_ctrl #(
  parameter logic [31:0] IO_BASE     = 32'hFFD00000,
  parameter logic [31:0] IO_MASK     = 32'hFFF00000,
  parameter int          CHK_TIMEOUT = 15,
  parameter int          DEV_TIMEOUT = 255
) (
  input logic          clk_i,
  input logic          rst_i,
  io_gate_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, FWD, RESP, ERR, REL} state_t;

  localparam logic [7:0] CHK_LIM = 8'(CHK_TIMEOUT);
  localparam logic [7:0] DEV_LIM = 8'(DEV_TIMEOUT);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [1:0]  cause_nxt;
  logic        req, io_hit;

  logic [31:0] adr_q, dat_q, rdat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [5:0]  asid_q;

  logic [31:0] fadr_q;
  logic [5:0]  fasid_q;
  logic [1:0]  fcause_q;

  assign req    = bus.s_cyc_i & bus.s_stb_i;
  assign io_hit = (bus.s_adr_i & IO_MASK) == IO_BASE;

  // Upstream abandon outranks any response; a gate reply outranks the check timeout.
  always_comb begin
    state_nxt = state;
    cause_nxt = 2'd0;
    case (state)
      IDLE: begin
        if (req) begin
          if (!io_hit) begin
            state_nxt = ERR;
            cause_nxt = 2'd1;
          end else if (bus.s_priv_i) begin
            state_nxt = FWD;
          end else begin
            state_nxt = CHECK;
          end
        end
      end
      CHECK: begin
        if (!bus.s_cyc_i) begin
          state_nxt = IDLE;
        end else if (bus.bm_gate_en_i) begin
          if (bus.bm_gate_i) begin
            state_nxt = FWD;
          end else begin
            state_nxt = ERR;
            cause_nxt = 2'd1;
          end
        end else if (cnt >= CHK_LIM) begin
          state_nxt = ERR;
          cause_nxt = 2'd2;
        end
      end
      FWD: begin
        if (!bus.s_cyc_i) begin
          state_nxt = IDLE;
        end else if (bus.m_ack_i) begin
          state_nxt = RESP;
        end else if (cnt >= DEV_LIM) begin
          state_nxt = ERR;
          cause_nxt = 2'd3;
        end
      end
      RESP:    state_nxt = REL;
      ERR:     state_nxt = REL;
      REL:     if (!bus.s_stb_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      adr_q    <= 32'd0;
      dat_q    <= 32'd0;
      rdat_q   <= 32'd0;
      sel_q    <= 4'd0;
      we_q     <= 1'b0;
      asid_q   <= 6'd0;
      fadr_q   <= 32'd0;
      fasid_q  <= 6'd0;
      fcause_q <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= 8'd0;
      end else if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
      if (state == IDLE && req) begin
        adr_q  <= bus.s_adr_i;
        dat_q  <= bus.s_dat_i;
        sel_q  <= bus.s_sel_i;
        we_q   <= bus.s_we_i;
        asid_q <= bus.s_asid_i;
      end
      if (state == FWD && bus.m_ack_i) begin
        rdat_q <= we_q ? 32'd0 : bus.m_dat_i;
      end
      // A misdecode faults straight out of IDLE, before the request registers hold the address.
      if (state_nxt == ERR && state != ERR) begin
        fcause_q <= cause_nxt;
        fadr_q   <= (state == IDLE) ? bus.s_adr_i : adr_q;
        fasid_q  <= (state == IDLE) ? bus.s_asid_i : asid_q;
      end
    end
  end

  assign bus.s_ack_o   = (state == RESP);
  assign bus.s_err_o   = (state == ERR);
  assign bus.s_dat_o   = (state == RESP) ? rdat_q : 32'd0;

  assign bus.bm_cyc_o  = (state == CHECK);
  assign bus.bm_stb_o  = (state == CHECK);
  assign bus.bm_iocs_o = (state == CHECK);
  assign bus.bm_asid_o = asid_q;
  assign bus.bm_adr_o  = adr_q[19:0];

  assign bus.m_cyc_o   = (state == FWD);
  assign bus.m_stb_o   = (state == FWD);
  assign bus.m_we_o    = (state == FWD) & we_q;
  assign bus.m_sel_o   = sel_q;
  assign bus.m_adr_o   = adr_q;
  assign bus.m_dat_o   = dat_q;

  assign bus.fault_o       = (state == ERR);
  assign bus.fault_adr_o   = fadr_q;
  assign bus.fault_asid_o  = fasid_q;
  assign bus.fault_cause_o = fcause_q;
endmodule
